// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: buffers per-retire records in a FIFO and drains them over valid/ready.
// Optional build macro COMMIT_TRACE_X0_FILTER_EN drops retires with no architectural write from capture.
module commit_trace_buffer #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_en_i,
    input  logic                       flush_i,
    input  logic                       ret_valid_i,
    input  logic [XLEN-1:0]            ret_pc_i,
    input  logic [31:0]                ret_instr_i,
    input  logic                       ret_rd_we_i,
    input  logic [4:0]                 ret_rd_addr_i,
    input  logic [XLEN-1:0]            ret_rd_data_i,
    input  logic                       ret_mem_we_i,
    input  logic [XLEN-1:0]            ret_mem_addr_i,
    input  logic [XLEN-1:0]            ret_mem_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic                       out_rd_we_o,
    output logic [4:0]                 out_rd_addr_o,
    output logic [XLEN-1:0]            out_rd_data_o,
    output logic                       out_mem_we_o,
    output logic [XLEN-1:0]            out_mem_addr_o,
    output logic [XLEN-1:0]            out_mem_data_o,
    output logic [SEQ_W-1:0]           out_seq_o,
    output logic                       out_gap_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
        logic             rd_we;
        logic [4:0]       rd_addr;
        logic [XLEN-1:0]  rd_data;
        logic             mem_we;
        logic [XLEN-1:0]  mem_addr;
        logic [XLEN-1:0]  mem_data;
        logic [SEQ_W-1:0] seq;
        logic             gap;
    } rec_t;

    rec_t               mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [DROP_W-1:0]  drop_q;
    logic               gap_pending_q;

    logic               keep;
    logic               observed;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;
    rec_t               wr_rec;
    rec_t               head_rec;

`ifdef COMMIT_TRACE_X0_FILTER_EN
    // Only retires that change architectural state (non-x0 write or store) are traced.
    assign keep = (ret_rd_we_i && (ret_rd_addr_i != 5'd0)) || ret_mem_we_i;
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        observed = ret_valid_i && trace_en_i && keep && !rst_i;
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        // A retire coinciding with flush is discarded: neither stored nor counted as a drop.
        pop      = !empty && out_ready_i && !flush_i;
        push     = observed && !flush_i && (!full || pop);
        drop     = observed && !flush_i && full && !pop;
    end

    always_comb begin
        wr_rec          = '0;
        wr_rec.pc       = ret_pc_i;
        wr_rec.instr    = ret_instr_i;
        wr_rec.rd_we    = ret_rd_we_i;
        wr_rec.rd_addr  = ret_rd_addr_i;
        wr_rec.rd_data  = ret_rd_data_i;
        wr_rec.mem_we   = ret_mem_we_i;
        wr_rec.mem_addr = ret_mem_addr_i;
        wr_rec.mem_data = ret_mem_data_i;
        wr_rec.seq      = seq_q;
        wr_rec.gap      = gap_pending_q;
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by level_q,
    // which lets the array map onto plain RAM without a reset network.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every update in this
    // block sees the pre-edge values computed by the combinational logic above.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            seq_q         <= '0;
            drop_q        <= '0;
            gap_pending_q <= 1'b0;
        end else begin
            if (observed) begin
                seq_q <= seq_q + SEQ_W'(1);
            end

            if (flush_i) begin
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                level_q       <= '0;
                gap_pending_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end

                case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase

                if (push) begin
                    gap_pending_q <= 1'b0;
                end else if (drop) begin
                    gap_pending_q <= 1'b1;
                end
            end

            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // Fields are forced to zero while empty so stale array contents never leak out.
    always_comb begin
        head_rec = empty ? '0 : mem[rd_ptr_q];
    end

    assign out_valid_o    = !empty;
    assign out_pc_o       = head_rec.pc;
    assign out_instr_o    = head_rec.instr;
    assign out_rd_we_o    = head_rec.rd_we;
    assign out_rd_addr_o  = head_rec.rd_addr;
    assign out_rd_data_o  = head_rec.rd_data;
    assign out_mem_we_o   = head_rec.mem_we;
    assign out_mem_addr_o = head_rec.mem_addr;
    assign out_mem_data_o = head_rec.mem_data;
    assign out_seq_o      = head_rec.seq;
    assign out_gap_o      = head_rec.gap;
    assign drop_cnt_o     = drop_q;
    assign level_o        = level_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (default DUT plus a DROP_W=2 instance).
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        flush;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [31:0] ret_instr;
    logic        ret_rd_we;
    logic [4:0]  ret_rd_addr;
    logic [31:0] ret_rd_data;
    logic        ret_mem_we;
    logic [31:0] ret_mem_addr;
    logic [31:0] ret_mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_rd_we;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_data;
    logic        out_mem_we;
    logic [31:0] out_mem_addr;
    logic [31:0] out_mem_data;
    logic [15:0] out_seq;
    logic        out_gap;
    logic [7:0]  drop_cnt;
    logic [4:0]  level;

    // Second instance for saturation: DEPTH=2, DROP_W=2.
    logic        rst2;
    logic        ret_valid2;
    logic        out_ready2;
    logic        out_valid2;
    logic [31:0] out_pc2;
    logic [31:0] out_instr2;
    logic        out_rd_we2;
    logic [4:0]  out_rd_addr2;
    logic [31:0] out_rd_data2;
    logic        out_mem_we2;
    logic [31:0] out_mem_addr2;
    logic [31:0] out_mem_data2;
    logic [15:0] out_seq2;
    logic        out_gap2;
    logic [1:0]  drop_cnt2;
    logic [1:0]  level2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(32), .DEPTH(16), .SEQ_W(16), .DROP_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .trace_en_i(trace_en), .flush_i(flush),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .ret_rd_we_i(ret_rd_we), .ret_rd_addr_i(ret_rd_addr), .ret_rd_data_i(ret_rd_data),
        .ret_mem_we_i(ret_mem_we), .ret_mem_addr_i(ret_mem_addr), .ret_mem_data_i(ret_mem_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_instr_o(out_instr), .out_rd_we_o(out_rd_we),
        .out_rd_addr_o(out_rd_addr), .out_rd_data_o(out_rd_data), .out_mem_we_o(out_mem_we),
        .out_mem_addr_o(out_mem_addr), .out_mem_data_o(out_mem_data),
        .out_seq_o(out_seq), .out_gap_o(out_gap), .drop_cnt_o(drop_cnt), .level_o(level)
    );

    commit_trace_buffer #(.XLEN(32), .DEPTH(2), .SEQ_W(16), .DROP_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst2), .trace_en_i(1'b1), .flush_i(1'b0),
        .ret_valid_i(ret_valid2), .ret_pc_i(32'h0), .ret_instr_i(32'h0),
        .ret_rd_we_i(1'b1), .ret_rd_addr_i(5'd3), .ret_rd_data_i(32'h0),
        .ret_mem_we_i(1'b0), .ret_mem_addr_i(32'h0), .ret_mem_data_i(32'h0),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .out_pc_o(out_pc2), .out_instr_o(out_instr2), .out_rd_we_o(out_rd_we2),
        .out_rd_addr_o(out_rd_addr2), .out_rd_data_o(out_rd_data2), .out_mem_we_o(out_mem_we2),
        .out_mem_addr_o(out_mem_addr2), .out_mem_data_o(out_mem_data2),
        .out_seq_o(out_seq2), .out_gap_o(out_gap2), .drop_cnt_o(drop_cnt2), .level_o(level2)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; trace_en = 1'b1; flush = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
        ret_pc = '0; ret_instr = '0; ret_rd_we = 1'b0; ret_rd_addr = '0; ret_rd_data = '0;
        ret_mem_we = 1'b0; ret_mem_addr = '0; ret_mem_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_retire(input logic [31:0] pc, input logic [31:0] instr,
                                input logic rd_we, input logic [4:0] rd,
                                input logic [31:0] rd_data, input logic mem_we,
                                input logic [31:0] ma, input logic [31:0] md);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_rd_we = rd_we;
        ret_rd_addr = rd; ret_rd_data = rd_data; ret_mem_we = mem_we;
        ret_mem_addr = ma; ret_mem_data = md;
        tick();
        ret_valid = 1'b0;
    endtask

    task automatic retire_n(input int n, input logic [31:0] base_pc);
        for (int i = 0; i < n; i++) begin
            drive_retire(base_pc + 32'(4 * i), 32'h00000013, 1'b1, 5'd2, 32'(i), 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_reset();
        rst2 = 1'b1; ret_valid2 = 1'b0; out_ready2 = 1'b0;
        do_reset();
        rst2 = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        checks++; if (out_pc !== 32'h0 || out_seq !== 16'h0) begin fails++;
            $display("FAIL reset_fields got pc=%h seq=%0d want 0/0", out_pc, out_seq); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        drive_retire(32'h00000010, 32'h00500093, 1'b1, 5'd1, 32'h5, 1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_pc !== 32'h10 || out_instr !== 32'h00500093) begin fails++;
            $display("FAIL single_pc_instr got %h/%h want 00000010/00500093", out_pc, out_instr); end
        checks++; if (out_rd_we !== 1'b1 || out_rd_addr !== 5'd1 || out_rd_data !== 32'h5) begin fails++;
            $display("FAIL single_rd got we=%0b rd=%0d data=%h want 1/1/5", out_rd_we, out_rd_addr, out_rd_data); end
        checks++; if (out_seq !== 16'd0 || out_gap !== 1'b0) begin fails++;
            $display("FAIL single_seq_gap got %0d/%0b want 0/0", out_seq, out_gap); end
        tick();
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin fails++;
            $display("FAIL single_drain got level=%0d valid=%0b want 0/0", level, out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        retire_n(20, 32'h00001000);
        checks++; if (level !== 5'd16) begin fails++; $display("FAIL bp_level got %0d want 16", level); end
        checks++; if (drop_cnt !== 8'd4) begin fails++; $display("FAIL bp_drop got %0d want 4", drop_cnt); end
        // Output must hold while stalled.
        tick();
        checks++; if (out_seq !== 16'd0 || out_pc !== 32'h00001000) begin fails++;
            $display("FAIL bp_hold got seq=%0d pc=%h want 0/00001000", out_seq, out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_gap !== 1'b0 || out_pc !== 32'h00001000 + 32'(4 * i)) begin
                fails++;
                $display("FAIL bp_drain[%0d] got valid=%0b seq=%0d gap=%0b pc=%h want 1/%0d/0/%h",
                         i, out_valid, out_seq, out_gap, out_pc, i, 32'h00001000 + 32'(4 * i));
            end
            tick();
        end
        checks++; if (level !== 5'd0) begin fails++; $display("FAIL bp_empty got %0d want 0", level); end
        drive_retire(32'h00002000, 32'h00000013, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_seq !== 16'd20 || out_gap !== 1'b1) begin fails++;
            $display("FAIL bp_gap got valid=%0b seq=%0d gap=%0b want 1/20/1", out_valid, out_seq, out_gap); end
    endtask

    task automatic test_full_pop();
        do_reset();
        retire_n(16, 32'h00003000);
        checks++; if (level !== 5'd16) begin fails++; $display("FAIL fp_fill got %0d want 16", level); end
        out_ready = 1'b1;
        drive_retire(32'h00003040, 32'h00000013, 1'b1, 5'd4, 32'h44, 1'b0, 32'h0, 32'h0);
        out_ready = 1'b0;
        checks++; if (level !== 5'd16) begin fails++; $display("FAIL fp_level got %0d want 16", level); end
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL fp_drop got %0d want 0", drop_cnt); end
        checks++; if (out_seq !== 16'd1) begin fails++; $display("FAIL fp_head got %0d want 1", out_seq); end
    endtask

    task automatic test_flush();
        do_reset();
        retire_n(5, 32'h00004000);
        flush = 1'b1;
        drive_retire(32'h00004014, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin fails++;
            $display("FAIL flush_level got level=%0d valid=%0b want 0/0", level, out_valid); end
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL flush_drop got %0d want 0", drop_cnt); end
        drive_retire(32'h00004018, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (out_seq !== 16'd6) begin fails++; $display("FAIL flush_seq got %0d want 6", out_seq); end

        // Flush with drops pending: counter kept, gap-pending cleared.
        do_reset();
        retire_n(18, 32'h00005000);
        flush = 1'b1;
        drive_retire(32'h00005048, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        checks++; if (drop_cnt !== 8'd2) begin fails++; $display("FAIL flush_keep_drop got %0d want 2", drop_cnt); end
        drive_retire(32'h0000504c, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (out_seq !== 16'd19 || out_gap !== 1'b0) begin fails++;
            $display("FAIL flush_gap_clear got seq=%0d gap=%0b want 19/0", out_seq, out_gap); end
    endtask

    task automatic test_trace_en();
        do_reset();
        trace_en = 1'b0;
        drive_retire(32'h00006000, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (level !== 5'd0 || drop_cnt !== 8'd0) begin fails++;
            $display("FAIL en_off got level=%0d drop=%0d want 0/0", level, drop_cnt); end
        trace_en = 1'b1;
        drive_retire(32'h00006004, 32'h00000013, 1'b1, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_seq !== 16'd0) begin fails++;
            $display("FAIL en_on got valid=%0b seq=%0d want 1/0", out_valid, out_seq); end
    endtask

    task automatic test_saturation();
        ret_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (drop_cnt2 !== 2'd2) begin fails++; $display("FAIL sat_mid got %0d want 2", drop_cnt2); end
        for (int i = 0; i < 4; i++) tick();
        ret_valid2 = 1'b0;
        checks++; if (drop_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cap got %0d want 3", drop_cnt2); end
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        checks++; if (drop_cnt2 !== 2'd0 || out_valid2 !== 1'b0 || level2 !== 2'd0) begin fails++;
            $display("FAIL sat_reset got drop=%0d valid=%0b level=%0d want 0/0/0", drop_cnt2, out_valid2, level2); end
        ret_valid2 = 1'b1;
        tick();
        ret_valid2 = 1'b0;
        checks++; if (out_valid2 !== 1'b1 || out_seq2 !== 16'd0) begin fails++;
            $display("FAIL sat_seq_restart got valid=%0b seq=%0d want 1/0", out_valid2, out_seq2); end
    endtask

    task automatic test_filter();
        do_reset();
        drive_retire(32'h00007000, 32'h00000013, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        drive_retire(32'h00007004, 32'h00b02023, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'hAB);
`ifdef COMMIT_TRACE_X0_FILTER_EN
        checks++; if (level !== 5'd1) begin fails++; $display("FAIL filt_level got %0d want 1", level); end
        checks++; if (out_seq !== 16'd0 || out_mem_we !== 1'b1 || out_mem_addr !== 32'h100 || out_mem_data !== 32'hAB) begin
            fails++;
            $display("FAIL filt_store got seq=%0d we=%0b addr=%h data=%h want 0/1/100/ab",
                     out_seq, out_mem_we, out_mem_addr, out_mem_data);
        end
`else
        checks++; if (level !== 5'd2) begin fails++; $display("FAIL filt_level got %0d want 2", level); end
        checks++; if (out_seq !== 16'd0 || out_rd_addr !== 5'd0 || out_mem_we !== 1'b0) begin fails++;
            $display("FAIL filt_first got seq=%0d rd=%0d mem_we=%0b want 0/0/0", out_seq, out_rd_addr, out_mem_we); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_seq !== 16'd1 || out_mem_addr !== 32'h100 || out_mem_data !== 32'hAB) begin fails++;
            $display("FAIL filt_second got seq=%0d addr=%h data=%h want 1/100/ab", out_seq, out_mem_addr, out_mem_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_trace_en();
        test_saturation();
        test_filter();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retirement trace capture for the RISC-V core.
- Buffers per-retire records in a parametrised FIFO: pc, instr, register write and memory write.
- Drains records through a valid/ready stream to a log or debug sink.
- Replaces bench-side free-running logging: adds back-pressure, loss detection (sequence numbers, gap flag, drop counter) and flush.

Parameters:
- XLEN, 32, data/address width of all trace fields.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- SEQ_W, 16, width of the retire sequence number.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- trace_en_i  in  1  capture enable; when 0 retires are ignored entirely.
- flush_i  in  1  synchronous FIFO clear.
- ret_valid_i  in  1  one instruction retired this cycle.
- ret_pc_i  in  XLEN  pc of retired instruction.
- ret_instr_i  in  32  instruction word.
- ret_rd_we_i  in  1  register file write performed.
- ret_rd_addr_i  in  5  destination register.
- ret_rd_data_i  in  XLEN  value written.
- ret_mem_we_i  in  1  data memory write performed.
- ret_mem_addr_i  in  XLEN  store address.
- ret_mem_data_i  in  XLEN  store data.
- out_valid_o  out  1  record available.
- out_ready_i  in  1  sink accepts record.
- out_pc_o, out_instr_o, out_rd_we_o, out_rd_addr_o, out_rd_data_o, out_mem_we_o, out_mem_addr_o, out_mem_data_o  out  as inputs  head record fields.
- out_seq_o  out  SEQ_W  sequence number of head record.
- out_gap_o  out  1  one or more records dropped immediately before this one.
- drop_cnt_o  out  DROP_W  saturating count of dropped records.
- level_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_i=1, synchronous): FIFO empty, out_valid_o=0, level_o=0, seq counter=0, drop_cnt_o=0, gap-pending=0. All out_* data fields read 0 while empty after reset.
- Observed retire: ret_valid_i && trace_en_i (subject to the optional filter).
  - Each observed retire takes the current seq value.
  - The seq counter increments by 1 mod 2^SEQ_W whether the record is stored or dropped.
- Push: occurs when an observed retire arrives and the FIFO is not full, or is full with a pop in the same cycle. A full FIFO with simultaneous pop accepts the push; level unchanged.
- Drop: an observed retire that cannot be pushed.
  - drop_cnt_o increments, saturating at 2^DROP_W-1.
  - gap-pending is set.
- Gap flag: the next pushed record stores gap=1 and clears gap-pending. A push in the same cycle as a drop is impossible, since there is one retire per cycle.
- Pop: out_valid_o && out_ready_i.
- Latency: a record pushed in cycle N is visible on out_* in cycle N+1 (out_valid_o=1 at N+1 if the FIFO was empty).
- Output stability: while out_valid_o=1 and out_ready_i=0, all out_* fields hold stable.
- out_ready_i while empty: no effect.
- Pointers: read/write pointers $clog2(DEPTH) bits, wrap naturally. Full when level_o==DEPTH.
- flush_i:
  - Next cycle: level_o=0, out_valid_o=0, gap-pending=0.
  - Seq counter and drop_cnt_o are preserved.
  - A retire in the same cycle as flush_i is discarded and not counted as a drop; seq still increments.
- Priority: rst_i > flush_i > push/pop.
- trace_en_i=0: no push, no drop, no seq increment. Draining continues normally.
- Reset mid-stream: contents are lost; no partial record is output.

Optional Feature:
- Macro: COMMIT_TRACE_X0_FILTER_EN.
- Defined: a retire with (ret_rd_we_i==0 or ret_rd_addr_i==0) and ret_mem_we_i==0 is not an observed retire. It is not stored, not counted, and seq does not increment.
- Undefined: every ret_valid_i && trace_en_i cycle is observed, including writes to x0 and branches.

Test Plan:
- Single retire: pc=0x00000010, instr=0x00500093, rd_we=1, rd=1, data=0x5, sink ready -> out_valid_o=1 the next cycle with those fields, seq=0, gap=0; level_o returns to 0 after the pop.
- Back-pressure fill: out_ready_i=0, 20 consecutive retires with DEPTH=16 -> level_o=16; drop_cnt_o=4; then raise ready -> 16 records with seq 0..15, all gap=0. Next retire -> seq=20, gap=1.
- Full with simultaneous pop: FIFO full, ready=1, retire the same cycle -> push accepted, drop_cnt_o unchanged, level_o stays 16.
- Flush: 5 records buffered, assert flush_i with a retire in the same cycle -> level_o=0 next cycle, drop_cnt_o unchanged; next retire seq=6.
- Saturation: DROP_W=2, 6 drops -> drop_cnt_o=3. rst_i -> drop_cnt_o=0, out_valid_o=0, seq restarts at 0.
- Filter (macro defined): retire rd=0 rd_we=1 mem_we=0, then store mem_addr=0x100 data=0xAB -> exactly one record (the store), seq=0. Macro undefined -> two records, seq 0 and 1.
